// File: rtl/alu381_sequencer_if.sv
// ---------------------------------------------------------------------------
// alu381_sequencer_if
//   Bundles the three channels around the ALU sequencer:
//     request  : req_valid/req_ready handshake carrying req_a, req_b, req_sel
//     ALU      : alu_a, alu_b, alu_s toward the ALU; alu_f, alu_c back
//     response : rsp_valid/rsp_ready handshake carrying rsp_f, rsp_c, rsp_err
//     status   : op_count, the number of completed responses (wraps at 256)
//   Modports:
//     slave  - the sequencer itself
//     master - its environment: the requesting master, the response consumer
//              and the combinational ALU slice
// ---------------------------------------------------------------------------
interface alu381_sequencer_if;
  // request channel
  logic       req_valid;
  logic       req_ready;
  logic [3:0] req_a;
  logic [3:0] req_b;
  logic [2:0] req_sel;

  // ALU operand/result channel
  logic [3:0] alu_a;
  logic [3:0] alu_b;
  logic [2:0] alu_s;
  logic [3:0] alu_f;
  logic       alu_c;

  // response channel
  logic       rsp_valid;
  logic       rsp_ready;
  logic [3:0] rsp_f;
  logic       rsp_c;
  logic       rsp_err;

  // status
  logic [7:0] op_count;

  modport slave (
    input  req_valid, req_a, req_b, req_sel,
    output req_ready,
    output alu_a, alu_b, alu_s,
    input  alu_f, alu_c,
    output rsp_valid, rsp_f, rsp_c, rsp_err,
    input  rsp_ready,
    output op_count
  );

  modport master (
    output req_valid, req_a, req_b, req_sel,
    input  req_ready,
    input  alu_a, alu_b, alu_s,
    output alu_f, alu_c,
    input  rsp_valid, rsp_f, rsp_c, rsp_err,
    output rsp_ready,
    input  op_count
  );
endinterface

// File: rtl/alu381_sequencer.sv
// ---------------------------------------------------------------------------
// alu381_sequencer
//   Issues one operation at a time to a 4-bit 74LS381-style ALU slice.
//   A request is accepted in IDLE; a supported select is applied to the ALU
//   and held for SETTLE_CYCLES cycles, after which {C,F} is captured and
//   returned on the response channel. Select 111 (preset) is not supported:
//   it is answered immediately with rsp_err=1 and {C,F}=0, leaving the ALU
//   inputs untouched.
//
//   Parameters:
//     SETTLE_CYCLES - cycles the ALU inputs are held before sampling (1..15)
//   Ports:
//     clk - rising-edge clock
//     rst - synchronous, active-high reset; aborts any operation in flight
//     bus - alu381_sequencer_if.slave (request, ALU, response, op_count)
// ---------------------------------------------------------------------------
module alu381_sequencer #(
  parameter int unsigned SETTLE_CYCLES = 1
) (
  input  logic               clk,
  input  logic               rst,
  alu381_sequencer_if.slave  bus
);

  // Terminal value of the settle counter; the counter starts at 0 on the
  // first DRIVE cycle, so this marks the SETTLE_CYCLES-th cycle.
  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);
  localparam logic [2:0] SEL_PRESET  = 3'b111;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    RESP  = 2'd2
  } state_t;

  state_t     state;
  state_t     state_nxt;

  logic [3:0] settle_cnt;
  logic [3:0] alu_a_q;
  logic [3:0] alu_b_q;
  logic [2:0] alu_s_q;
  logic [3:0] rsp_f_q;
  logic       rsp_c_q;
  logic       rsp_err_q;
  logic [7:0] op_count_q;

  logic       req_fire;
  logic       rsp_fire;
  logic       sel_bad;
  logic       settle_done;

  // Handshake flags come straight from the state register, so they are
  // stable for the whole cycle.
  assign bus.req_ready = (state == IDLE);
  assign bus.rsp_valid = (state == RESP);

  assign req_fire    = bus.req_valid && (state == IDLE);
  assign rsp_fire    = bus.rsp_ready && (state == RESP);
  assign sel_bad     = (bus.req_sel == SEL_PRESET);
  assign settle_done = (state == DRIVE) && (settle_cnt == SETTLE_LAST);

  // -------------------------------------------------------------------------
  // State register
  // -------------------------------------------------------------------------
  // NOTE: sequential blocks use non-blocking (<=) so every flop samples the
  // pre-edge values of its inputs regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  // NOTE: the default assignment first keeps every path assigned, so no latch
  // is inferred for state_nxt.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (req_fire) begin
          state_nxt = sel_bad ? RESP : DRIVE;
        end
      end
      DRIVE: begin
        if (settle_done) begin
          state_nxt = RESP;
        end
      end
      RESP: begin
        if (rsp_fire) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // Datapath: ALU operand registers, settle counter, response capture
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      settle_cnt <= 4'd0;
      alu_a_q    <= 4'd0;
      alu_b_q    <= 4'd0;
      alu_s_q    <= 3'b000;
      rsp_f_q    <= 4'd0;
      rsp_c_q    <= 1'b0;
      rsp_err_q  <= 1'b0;
      op_count_q <= 8'd0;
    end else begin
      if (state == DRIVE) begin
        settle_cnt <= settle_cnt + 4'd1;
      end

      if (req_fire) begin
        settle_cnt <= 4'd0;
        if (sel_bad) begin
          // Unsupported select: answer at once, ALU inputs keep old values.
          rsp_f_q   <= 4'd0;
          rsp_c_q   <= 1'b0;
          rsp_err_q <= 1'b1;
        end else begin
          alu_a_q <= bus.req_a;
          alu_b_q <= bus.req_b;
          alu_s_q <= bus.req_sel;
        end
      end

      // {C,F} is returned verbatim; the sequencer never interprets it.
      if (settle_done) begin
        rsp_f_q   <= bus.alu_f;
        rsp_c_q   <= bus.alu_c;
        rsp_err_q <= 1'b0;
      end

      // Error responses count as completed operations too.
      if (rsp_fire) begin
        op_count_q <= op_count_q + 8'd1;
      end
    end
  end

  assign bus.alu_a    = alu_a_q;
  assign bus.alu_b    = alu_b_q;
  assign bus.alu_s    = alu_s_q;
  assign bus.rsp_f    = rsp_f_q;
  assign bus.rsp_c    = rsp_c_q;
  assign bus.rsp_err  = rsp_err_q;
  assign bus.op_count = op_count_q;

endmodule

// File: tb/tb_alu381_sequencer.sv
// ---------------------------------------------------------------------------
// tb_alu381_sequencer
//   Directed bench for alu381_sequencer. Two instances are exercised: one
//   with the default SETTLE_CYCLES=1 and one with SETTLE_CYCLES=4. Each is
//   attached to a behavioural 74LS381-style ALU slice. Expected values are
//   hand-computed constants.
// ---------------------------------------------------------------------------
module tb_alu381_sequencer;

  logic clk;
  logic rst;

  int total;
  int bad;

  alu381_sequencer_if bus1 ();
  alu381_sequencer_if bus4 ();

  alu381_sequencer #(.SETTLE_CYCLES(1)) u_dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1)
  );

  alu381_sequencer #(.SETTLE_CYCLES(4)) u_dut4 (
    .clk (clk),
    .rst (rst),
    .bus (bus4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural ALU slice. Subtraction is A + ~B + 1, so C is the
  // "no borrow" carry out. Preset drives all ones so an erroneous capture
  // of it would be visible.
  function automatic logic [4:0] alu_model(input logic [3:0] a,
                                           input logic [3:0] b,
                                           input logic [2:0] s);
    logic [4:0] r;
    r = 5'd0;
    case (s)
      3'b000: r = 5'd0;
      3'b001: r = {1'b0, b} + {1'b0, ~a} + 5'd1;
      3'b010: r = {1'b0, a} + {1'b0, ~b} + 5'd1;
      3'b011: r = {1'b0, a} + {1'b0, b};
      3'b100: r = {1'b0, a ^ b};
      3'b101: r = {1'b0, a | b};
      3'b110: r = {1'b0, a & b};
      default: r = 5'b1_1111;
    endcase
    return r;
  endfunction

  always_comb {bus1.alu_c, bus1.alu_f} = alu_model(bus1.alu_a, bus1.alu_b, bus1.alu_s);
  always_comb {bus4.alu_c, bus4.alu_f} = alu_model(bus4.alu_a, bus4.alu_b, bus4.alu_s);

  typedef struct packed {
    logic       req_ready;
    logic       rsp_valid;
    logic       rsp_c;
    logic [3:0] rsp_f;
    logic       rsp_err;
    logic [3:0] alu_a;
    logic [3:0] alu_b;
    logic [2:0] alu_s;
    logic [7:0] op_count;
  } obs_t;

  localparam obs_t OBS_RESET = '{req_ready: 1'b1, default: '0};

  function automatic obs_t obs(input int d);
    obs_t o;
    if (d == 0) begin
      o = '{bus1.req_ready, bus1.rsp_valid, bus1.rsp_c, bus1.rsp_f, bus1.rsp_err,
            bus1.alu_a, bus1.alu_b, bus1.alu_s, bus1.op_count};
    end else begin
      o = '{bus4.req_ready, bus4.rsp_valid, bus4.rsp_c, bus4.rsp_f, bus4.rsp_err,
            bus4.alu_a, bus4.alu_b, bus4.alu_s, bus4.op_count};
    end
    return o;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_req(input int d, input logic v, input logic [3:0] a,
                           input logic [3:0] b, input logic [2:0] s);
    if (d == 0) begin
      bus1.req_valid = v; bus1.req_a = a; bus1.req_b = b; bus1.req_sel = s;
    end else begin
      bus4.req_valid = v; bus4.req_a = a; bus4.req_b = b; bus4.req_sel = s;
    end
  endtask

  task automatic set_rsp_ready(input int d, input logic r);
    if (d == 0) bus1.rsp_ready = r;
    else        bus4.rsp_ready = r;
  endtask

  // Waits (bounded) for rsp_valid; lat counts cycles from the acceptance edge.
  task automatic wait_rsp(input int d, output int lat, output obs_t o);
    lat = 1;
    o = obs(d);
    while (!o.rsp_valid && lat < 40) begin
      tick();
      lat++;
      o = obs(d);
    end
  endtask

  // One complete request/response transaction with checks on latency,
  // response payload, ALU drive and the post-handshake state.
  task automatic run_op(input int d, input string tag,
                        input logic [3:0] a, input logic [3:0] b, input logic [2:0] s,
                        input logic [4:0] exp_cf, input logic exp_err, input int exp_lat,
                        input logic [10:0] exp_alu, input logic [7:0] exp_cnt);
    obs_t o;
    int   w;
    int   lat;
    drive_req(d, 1'b1, a, b, s);
    w = 0;
    o = obs(d);
    while (!o.req_ready && w < 40) begin
      tick();
      w++;
      o = obs(d);
    end
    check({tag, "_accept"}, o.req_ready, 1);
    tick();
    drive_req(d, 1'b0, 4'd0, 4'd0, 3'd0);
    wait_rsp(d, lat, o);
    check({tag, "_lat"}, lat, exp_lat);
    check({tag, "_cf"}, {o.rsp_c, o.rsp_f}, exp_cf);
    check({tag, "_err"}, o.rsp_err, exp_err);
    check({tag, "_alu"}, {o.alu_a, o.alu_b, o.alu_s}, exp_alu);
    set_rsp_ready(d, 1'b1);
    tick();
    set_rsp_ready(d, 1'b0);
    o = obs(d);
    check({tag, "_after"}, {o.rsp_valid, o.req_ready}, 2'b01);
    check({tag, "_cnt"}, o.op_count, exp_cnt);
  endtask

  initial begin
    obs_t o;
    obs_t o_hold;
    int   lat;
    int   w;
    int   hold_bad;
    int   seen;

    total = 0;
    bad   = 0;
    rst   = 1'b1;
    drive_req(0, 1'b0, 4'd0, 4'd0, 3'd0);
    drive_req(1, 1'b0, 4'd0, 4'd0, 3'd0);
    set_rsp_ready(0, 1'b0);
    set_rsp_ready(1, 1'b0);
    tick();
    tick();
    rst = 1'b0;

    // Reset state, then idle with no requests.
    check("reset_d1", obs(0), OBS_RESET);
    check("reset_d4", obs(1), OBS_RESET);
    repeat (5) tick();
    check("idle_hold_d1", obs(0), OBS_RESET);

    // Arithmetic and logic ops, SETTLE_CYCLES=1.
    run_op(0, "add",  4'hF, 4'h1, 3'b011, 5'b1_0000, 1'b0, 2, {4'hF, 4'h1, 3'b011}, 8'd1);
    run_op(0, "amb",  4'hF, 4'h1, 3'b010, 5'b1_1110, 1'b0, 2, {4'hF, 4'h1, 3'b010}, 8'd2);
    run_op(0, "bma",  4'h3, 4'hF, 3'b001, 5'b1_1100, 1'b0, 2, {4'h3, 4'hF, 3'b001}, 8'd3);
    run_op(0, "xor",  4'hA, 4'hC, 3'b100, 5'b0_0110, 1'b0, 2, {4'hA, 4'hC, 3'b100}, 8'd4);
    run_op(0, "or",   4'hA, 4'hC, 3'b101, 5'b0_1110, 1'b0, 2, {4'hA, 4'hC, 3'b101}, 8'd5);
    run_op(0, "and",  4'hA, 4'hC, 3'b110, 5'b0_1000, 1'b0, 2, {4'hA, 4'hC, 3'b110}, 8'd6);
    run_op(0, "clr",  4'hA, 4'hC, 3'b000, 5'b0_0000, 1'b0, 2, {4'hA, 4'hC, 3'b000}, 8'd7);
    // Unsupported select: immediate error, ALU inputs unchanged.
    run_op(0, "pre",  4'h5, 4'h6, 3'b111, 5'b0_0000, 1'b1, 1, {4'hA, 4'hC, 3'b000}, 8'd8);
    // A good op after an error clears rsp_err.
    run_op(0, "add2", 4'h7, 4'h8, 3'b011, 5'b0_1111, 1'b0, 2, {4'h7, 4'h8, 3'b011}, 8'd9);

    // Backpressure, SETTLE_CYCLES=4, with a second request held while busy.
    drive_req(1, 1'b1, 4'h5, 4'h3, 3'b011);
    check("bp_ready0", bus4.req_ready, 1);
    tick();
    drive_req(1, 1'b1, 4'h1, 4'h2, 3'b011);
    wait_rsp(1, lat, o);
    check("bp_lat", lat, 5);
    check("bp_cf", {o.rsp_c, o.rsp_f}, 5'b0_1000);
    check("bp_busy", {o.req_ready, o.alu_a}, {1'b0, 4'h5});
    o_hold   = o;
    hold_bad = 0;
    repeat (10) begin
      tick();
      if (obs(1) !== o_hold) hold_bad++;
    end
    check("bp_hold", hold_bad, 0);
    set_rsp_ready(1, 1'b1);
    tick();
    set_rsp_ready(1, 1'b0);
    o = obs(1);
    check("bp_after", {o.rsp_valid, o.req_ready, o.op_count}, {2'b01, 8'd1});
    check("bp_not_yet", o.alu_a, 4'h5);
    tick();
    drive_req(1, 1'b0, 4'd0, 4'd0, 3'd0);
    o = obs(1);
    check("bp_second_acc", {o.req_ready, o.alu_a, o.alu_b}, {1'b0, 4'h1, 4'h2});
    wait_rsp(1, lat, o);
    check("bp2_lat", lat, 5);
    check("bp2_cf", {o.rsp_c, o.rsp_f, o.rsp_err}, {5'b0_0011, 1'b0});
    set_rsp_ready(1, 1'b1);
    tick();
    set_rsp_ready(1, 1'b0);
    check("bp2_cnt", bus4.op_count, 8'd2);

    // Reset in the middle of DRIVE: operation aborted, no response.
    drive_req(1, 1'b1, 4'h7, 4'h7, 3'b011);
    tick();
    drive_req(1, 1'b0, 4'd0, 4'd0, 3'd0);
    tick();
    check("rst_in_drive", {bus4.req_ready, bus4.rsp_valid}, 2'b00);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_abort", obs(1), OBS_RESET);
    seen = 0;
    repeat (10) begin
      tick();
      if (bus4.rsp_valid) seen++;
    end
    check("rst_no_rsp", seen, 0);

    // 256 back-to-back operations wrap op_count (dut1 was reset above).
    set_rsp_ready(0, 1'b1);
    drive_req(0, 1'b1, 4'h2, 4'h4, 3'b011);
    for (int i = 0; i < 256; i++) begin
      if (i == 255) check("wrap_255", bus1.op_count, 8'd255);
      w = 0;
      while (!bus1.req_ready && w < 20) begin
        tick();
        w++;
      end
      tick();
      wait_rsp(0, lat, o);
      tick();
    end
    drive_req(0, 1'b0, 4'd0, 4'd0, 3'd0);
    set_rsp_ready(0, 1'b0);
    check("wrap_0", bus1.op_count, 8'd0);
    check("wrap_last_cf", {bus1.rsp_c, bus1.rsp_f}, 5'b0_0110);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
